ring_counter_n: RTL
===================

# ring_counter_n

- Parametrised shift-register counter; the general-purpose successor to the team's fixed 8-bit one-hot ring counter.
- Modes: one-hot ring, Johnson (twisted ring) and hold, with selectable shift direction, parallel load and illegal-state self-recovery.
- Registered outputs: a step index and a single-cycle wrap pulse.
- Used as a sequencer and phase generator in the lab designs (LED chasers, multiplexed display scan, multi-phase enables).

## Interface

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- RESET_VAL, {{(WIDTH-1){1'b0}},1'b1}, value loaded into count on reset.

Derived:
- IDXW = $clog2(2*WIDTH), index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- en  in  1  step enable; one step per cycle while high.
- dir  in  1  0 = left (bit i moves to bit i+1); 1 = right (bit i moves to bit i-1).
- mode  in  2  00 = ring, 01 = Johnson, 10/11 = hold.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value written into count when load is high.
- count  out  WIDTH  counter state, registered.
- index  out  IDXW  steps taken since the last reset/load/recovery, modulo the period, registered.
- wrap  out  1  one-cycle pulse when index rolls over, registered.
- err  out  1  one-cycle pulse when an illegal state was recovered, registered.

## Operation

- Priority at each rising edge: reset > load > step (en & mode in {00,01}) > hold.
- Reset: count=RESET_VAL, index=0, wrap=0, err=0.
- Load: count=load_val, index=0, wrap=0, err=0.
  - No legality check at load time; any value is accepted.
- Hold (en=0 or mode=1x): count and index keep their values; wrap=0, err=0.

Step behaviour:
- Ring, left: count <= {count[W-2:0], count[W-1]}.
- Ring, right: count <= {count[0], count[W-1:1]}.
- Johnson, left: count <= {count[W-2:0], ~count[W-1]}.
- Johnson, right: count <= {~count[0], count[W-1:1]}.
- Period P: WIDTH in ring mode, 2*WIDTH in Johnson mode.

Index and wrap:
- Left step: index+1, wrapping P-1 -> 0.
- Right step: index-1, wrapping 0 -> P-1.
- wrap=1 on exactly those rollover steps.

Legality, checked on every step against the current count:
- Ring: count must be exactly one-hot.
- Johnson: at most one adjacent-bit difference across count[W-1:0] (non-cyclic).

Illegal state on a step:
- No shift occurs.
- count <= RESET_VAL in ring mode, all-zeros in Johnson mode.
- index=0, err=1, wrap=0.

Mode and direction changes:
- A mode change takes effect at the next edge.
- count is not rewritten and index is not re-aligned; software issues a load after switching mode.
- dir may change on any cycle; a reversal simply reverses the sequence.

## Timing

- All outputs come directly from flops; no combinational path from any input to any output.
- Latency is one cycle: inputs sampled at edge k are reflected on count/index/wrap/err after edge k.
- wrap and err are high for exactly one cycle per event; consecutive events give consecutive pulses.
- Back-to-back steps are sustained at one per clock with no bubbles.
- reset asserted mid-sequence, including together with load and en, gives reset values at that edge.
- Coverage requirement: WIDTH=2 must work in both modes (ring period 2, Johnson period 4).

## Test plan

- Ring, left, WIDTH=8, reset then en=1 for 8 cycles:
  - count 02,04,08,10,20,40,80,01.
  - index 1..7,0.
  - wrap high only on the cycle count returns to 01.
- Ring, right, from reset:
  - count 80,40 on the first two steps.
  - index 7,6.
  - wrap high on the first step only.
- Johnson, left, from reset (01):
  - count 03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00,01.
  - wrap on the 16th step, index back to 0.
- Load 8'h05 in ring mode, then one step:
  - After load: count=05, index=0.
  - After the step: count=01, err=1 for one cycle.
  - Next step: count=02, err=0.
- Load 8'h66 in Johnson mode, then one step:
  - count=00, err=1.
  - Next step: count=01.
- Control and priority checks:
  - en=0 or mode=10 for 5 cycles: count/index frozen, wrap=err=0.
  - reset, load=1 and en=1 in the same cycle mid-sequence: count=01, index=0.

Source files
------------

// File: rtl/ring_counter_n.sv
// Parametrised shift-register counter: one-hot ring, Johnson or hold, either direction,
// with parallel load, a step index, a wrap pulse and recovery from illegal states.
module ring_counter_n #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1},
    localparam int unsigned      IDXW      = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [IDXW-1:0]  index,
    output logic             wrap,
    output logic             err
);

    // Last index of each sequence; the period itself may not fit in IDXW bits.
    localparam logic [IDXW-1:0] RING_LAST = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] JOHN_LAST = IDXW'(2*WIDTH - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [IDXW-1:0]  index_q, index_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             is_ring;
    logic             step_en;
    logic             ring_ok;
    logic             john_ok;
    logic             legal;
    logic [WIDTH-2:0] adj_diff;
    logic [WIDTH-1:0] shifted;
    logic [IDXW-1:0]  last_idx;
    logic [IDXW-1:0]  idx_next;
    logic             wrap_step;

    assign is_ring = (mode == 2'b00);
    assign step_en = en && !mode[1];

    always_comb begin
        ring_ok  = (count_q != '0) && ((count_q & (count_q - WIDTH'(1))) == '0);
        // Johnson states have at most one boundary between adjacent bits.
        adj_diff = count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0];
        john_ok  = (adj_diff & (adj_diff - (WIDTH-1)'(1))) == '0;
        legal    = is_ring ? ring_ok : john_ok;
    end

    always_comb begin
        shifted = count_q;
        case ({is_ring, dir})
            2'b10:   shifted = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            2'b11:   shifted = {count_q[0], count_q[WIDTH-1:1]};
            2'b00:   shifted = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            default: shifted = {~count_q[0], count_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        last_idx  = is_ring ? RING_LAST : JOHN_LAST;
        idx_next  = index_q;
        wrap_step = 1'b0;
        if (!dir) begin
            // An index left out of range by a mode switch also rolls over.
            wrap_step = (index_q >= last_idx);
            idx_next  = wrap_step ? '0 : index_q + IDXW'(1);
        end else begin
            wrap_step = (index_q == '0);
            idx_next  = wrap_step ? last_idx : index_q - IDXW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        index_d = index_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            count_d = load_val;
            index_d = '0;
        end else if (step_en) begin
            if (!legal) begin
                count_d = is_ring ? RESET_VAL : '0;
                index_d = '0;
                err_d   = 1'b1;
            end else begin
                count_d = shifted;
                index_d = idx_next;
                wrap_d  = wrap_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
            index_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            index_q <= index_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign index = index_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule
